// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed 8-digit seven-segment driver for the pipeline debug pins.
//   Digits 0-3 show the captured write-back data (NumberA[15:0]) and digits
//   4-7 show the captured PC (NumberB[15:0]). Each digit owns REFRESH_DIV
//   clock cycles. The first BLANK_CYCLES of every digit period disable all
//   digits so the previous digit's segments do not ghost onto the next one.
//
// Parameters
//   REFRESH_DIV  : clock cycles per digit period (>= 2)
//   BLANK_CYCLES : all-off cycles at the start of each period (0..REFRESH_DIV-1)
//
// Ports
//   Clk_in  : system clock, rising edge
//   Rst     : asynchronous reset, active low
//   NumberA : write-back data; only [15:0] is displayed
//   NumberB : PC; only [15:0] is displayed
//   Capture : load NumberA/NumberB into the holding registers at the edge
//   out7    : segments, active low, out7[6]=a ... out7[0]=g
//   en_out  : digit enables, active low, en_out[0] = rightmost digit
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic        Clk_in,
   input  logic        Rst,
   input  logic [31:0] NumberA,
   input  logic [31:0] NumberB,
   input  logic        Capture,
   output logic [6:0]  out7,
   output logic [7:0]  en_out
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

   // Holding registers
   logic [15:0] holdA_q, holdA_d;
   logic [15:0] holdB_q, holdB_d;

   // Prescaler and digit index
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    dig_q, dig_d;

   // Output registers
   logic [6:0] seg_q, seg_d;
   logic [7:0] en_q,  en_d;

   logic [15:0] hold_sel;
   logic [3:0]  nibble;
   logic        blank;

   // -------------------------------------------------------------------------
   // Hex to active-low abcdefg
   // -------------------------------------------------------------------------
   function automatic logic [6:0] hex2seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0:    s = 7'b0000001;
         4'h1:    s = 7'b1001111;
         4'h2:    s = 7'b0010010;
         4'h3:    s = 7'b0000110;
         4'h4:    s = 7'b1001100;
         4'h5:    s = 7'b0100100;
         4'h6:    s = 7'b0100000;
         4'h7:    s = 7'b0001111;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0000100;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b1100000;
         4'hC:    s = 7'b0110001;
         4'hD:    s = 7'b1000010;
         4'hE:    s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   // -------------------------------------------------------------------------
   // Blanking window. With no blank cycles the compare would be constant
   // false, so it is removed entirely rather than left as a dead compare.
   // -------------------------------------------------------------------------
   generate
      if (BLANK_CYCLES == 0) begin : g_noblank
         assign blank = 1'b0;
      end else begin : g_blank
         assign blank = (cnt_q < CW'(BLANK_CYCLES));
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Nibble select: dig[2] picks the source word, dig[1:0] the nibble.
   // Uses the registered hold values, so a capture at a digit change shows up
   // on the output one edge later and never mixes old and new nibbles.
   // -------------------------------------------------------------------------
   always_comb begin
      hold_sel = dig_q[2] ? holdB_q : holdA_q;
      nibble   = hold_sel[{dig_q[1:0], 2'b00} +: 4];
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      holdA_d = holdA_q;
      holdB_d = holdB_q;
      cnt_d   = cnt_q;
      dig_d   = dig_q;

      if (Capture) begin
         holdA_d = NumberA[15:0];
         holdB_d = NumberB[15:0];
      end

      if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
         dig_d = dig_q + 3'd1;   // 3-bit wrap 7 -> 0
      end else begin
         cnt_d = cnt_q + CW'(1);
      end

      // Outputs follow the current cnt/dig/hold with one cycle of latency.
      seg_d = hex2seg(nibble);
      en_d  = blank ? 8'hFF : ~(8'h01 << dig_q);
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge Clk_in or negedge Rst) begin
      if (!Rst) begin
         holdA_q <= '0;
         holdB_q <= '0;
         cnt_q   <= '0;
         dig_q   <= '0;
         seg_q   <= 7'h7F;
         en_q    <= 8'hFF;
      end else begin
         holdA_q <= holdA_d;
         holdB_q <= holdB_d;
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
         seg_q   <= seg_d;
         en_q    <= en_d;
      end
   end

   assign out7   = seg_q;
   assign en_out = en_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver. Two instances share all inputs: one with one
// blank cycle per digit, one with none. Expected outputs come from a cycle
// index since reset release plus the captured hold words.
module tb_seg7_scan_driver;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] na = '0, nb = '0;
   logic        cap = 1'b0;
   logic [6:0]  seg_a, seg_b;
   logic [7:0]  en_a, en_b;

   int n_chk = 0;
   int n_fail = 0;

   // model state
   int          k = 0;        // edges since reset release
   logic [15:0] mA = '0, mB = '0;

   logic [6:0] SEG [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   always #5 clk = ~clk;

   seg7_scan_driver #(.REFRESH_DIV(D), .BLANK_CYCLES(1)) u_a (
      .Clk_in(clk), .Rst(rst_n), .NumberA(na), .NumberB(nb),
      .Capture(cap), .out7(seg_a), .en_out(en_a));

   seg7_scan_driver #(.REFRESH_DIV(D), .BLANK_CYCLES(0)) u_b (
      .Clk_in(clk), .Rst(rst_n), .NumberA(na), .NumberB(nb),
      .Capture(cap), .out7(seg_b), .en_out(en_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_en(input int kk, input int blank);
      int c, d;
      c = kk % D;
      d = (kk / D) % 8;
      if (c < blank) return 8'hFF;
      return ~(8'h01 << d);
   endfunction

   function automatic logic [6:0] exp_seg(input int kk);
      int d;
      logic [15:0] w;
      d = (kk / D) % 8;
      w = (d < 4) ? mA : mB;
      return SEG[(w >> (4 * (d % 4))) & 16'hF];
   endfunction

   // One clock edge: compute expectations from pre-edge model state,
   // advance the model, then sample just after the edge.
   task automatic tick();
      logic [7:0] ea, eb;
      logic [6:0] es;
      ea = exp_en(k, 1);
      eb = exp_en(k, 0);
      es = exp_seg(k);
      @(posedge clk);
      if (cap) begin
         mA = na[15:0];
         mB = nb[15:0];
      end
      k++;
      #1;
      chk("en_blank1", {24'h0, en_a}, {24'h0, ea});
      chk("en_blank0", {24'h0, en_b}, {24'h0, eb});
      chk("seg_blank1", {25'h0, seg_a}, {25'h0, es});
      chk("seg_blank0", {25'h0, seg_b}, {25'h0, es});
      chk("one_hot_en", {31'h0, ($countones(~en_a) <= 1) && ($countones(~en_b) <= 1)}, 32'h1);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int ffa, ffb, guard;
      logic [31:0] sweep [4];
      sweep[0] = 32'h0000_3210;
      sweep[1] = 32'h0000_7654;
      sweep[2] = 32'h0000_BA98;
      sweep[3] = 32'h0000_FEDC;

      // Reset held with inputs toggling: everything stays off
      #1 rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         na = $urandom; nb = $urandom; cap = 1'b1;
         @(posedge clk); #1;
         chk("rst_en", {24'h0, en_a}, 32'hFF);
         chk("rst_seg", {25'h0, seg_a}, 32'h7F);
         chk("rst_en_b", {24'h0, en_b}, 32'hFF);
      end
      @(negedge clk);
      rst_n = 1'b1;
      k = 0; mA = '0; mB = '0;

      // Basic scan
      na = 32'h0000_1234; nb = 32'h0040_0008; cap = 1'b1;
      tick();
      cap = 1'b0;
      run(36);

      // Hold behaviour
      na = 32'hFFFF_FFFF;
      run(16);
      cap = 1'b1;
      tick();
      cap = 1'b0;
      run(16);

      // Decode sweep
      for (int s = 0; s < 4; s++) begin
         na = sweep[s]; cap = 1'b1;
         tick();
         cap = 1'b0;
         run(32);
      end

      // Three full scans: blank cycles per boundary, none without blanking
      ffa = 0; ffb = 0;
      for (int i = 0; i < 3 * 8 * D; i++) begin
         tick();
         if (en_a == 8'hFF) ffa++;
         if (en_b == 8'hFF) ffb++;
      end
      chk("ff_count_blank1", ffa, 3 * 8);
      chk("ff_count_blank0", ffb, 0);

      // Random traffic
      for (int i = 0; i < 200; i++) begin
         na = $urandom; nb = $urandom;
         cap = ($urandom_range(0, 3) == 0);
         tick();
      end
      cap = 1'b0;

      // Reset mid-scan at dig=5, cnt=2
      guard = 0;
      while (!((k % D) == 2 && ((k / D) % 8) == 5) && guard < 64) begin
         tick();
         guard++;
      end
      chk("reach_dig5", {31'h0, guard < 64}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_en", {24'h0, en_a}, 32'hFF);
      chk("async_rst_seg", {25'h0, seg_a}, 32'h7F);
      chk("async_rst_en_b", {24'h0, en_b}, 32'hFF);
      @(posedge clk); #1;
      chk("rst_hold_en", {24'h0, en_a}, 32'hFF);
      @(negedge clk);
      rst_n = 1'b1;
      k = 0; mA = '0; mB = '0;
      @(posedge clk); #1;
      chk("post_rst_blank", {24'h0, en_a}, 32'hFF);
      chk("post_rst_b_en", {24'h0, en_b}, 32'hFE);
      chk("post_rst_b_seg", {25'h0, seg_b}, {25'h0, 7'b0000001});
      k = 1;
      @(posedge clk); #1;
      chk("post_rst_en", {24'h0, en_a}, 32'hFE);
      chk("post_rst_seg", {25'h0, seg_a}, {25'h0, 7'b0000001});
      k = 2;
      run(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed 8-digit seven-segment driver that consumes the processor's debug outputs: the write-back data pin and the PC pin.
- Captures both 32-bit values into holding registers on a strobe.
- Scans digits 0-3 from NumberA[15:0] (write data) and digits 4-7 from NumberB[15:0] (PC).
- Drives active-low segments and digit enables.
- Inserts blanking at each digit change to suppress ghosting.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit period; legal range >= 2
BLANK_CYCLES, 2, cycles at the start of each digit period with all digits disabled; legal range 0..REFRESH_DIV-1

Ports:
Clk_in  input  1  system clock; all state updates on rising edge
Rst  input  1  asynchronous, active-low reset
NumberA  input  32  write-back data from the pipeline; only [15:0] is displayed
NumberB  input  32  PC from the pipeline; only [15:0] is displayed
Capture  input  1  when high at a rising edge, load NumberA/NumberB into the holding registers
out7  output  7  segments, active-low; out7[6]=a ... out7[0]=g
en_out  output  8  digit enables, active-low; en_out[0] = rightmost digit

Behaviour:
- Reset (Rst low, asynchronous, held while low):
  - holdA = 0, holdB = 0, prescaler cnt = 0, digit index dig = 0
  - en_out = 8'hFF, out7 = 7'h7F (all off)
- Holding registers:
  - On a rising edge with Capture = 1: holdA <= NumberA[15:0], holdB <= NumberB[15:0].
  - Capture = 0: hold their value.
  - Capture may stay high continuously (live display).
- Prescaler, evaluated each rising edge:
  - if cnt == REFRESH_DIV-1: cnt <= 0 and dig <= dig+1 (3-bit, wraps 7 -> 0)
  - else: cnt <= cnt+1
- Nibble select (combinational from dig):
  - dig 0..3 -> holdA[4*dig+3 : 4*dig]
  - dig 4..7 -> holdB[4*(dig-4)+3 : 4*(dig-4)]
- Outputs, registered (1-cycle latency from cnt/dig/hold):
  - if cnt < BLANK_CYCLES: en_out <= 8'hFF
  - else: en_out <= ~(8'b1 << dig)
  - out7 <= hex decode of the selected nibble, updated every cycle including blank cycles
- Hex decode, active-low abcdefg:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Capture coinciding with a digit change:
  - The new hold value takes effect in the hold register at that edge.
  - The output register reflects it one edge later.
  - The digit being shown never mixes old and new nibbles within one output cycle.
- Enable invariants:
  - At most one en_out bit is low in any cycle.
  - With BLANK_CYCLES = 0, there are no all-high gaps after reset.
- Reset asserted mid-scan: outputs return to all-off immediately (asynchronous); after release, scanning restarts at dig = 0, cnt = 0.
- Full scan period = 8*REFRESH_DIV cycles.

Test Plan:
- Reset state: hold Rst low with inputs toggling -> en_out = 8'hFF, out7 = 7'h7F throughout; no scanning.
- Basic scan (REFRESH_DIV=4, BLANK_CYCLES=1): Capture pulse with NumberA=32'h0000_1234, NumberB=32'h0040_0008, then Capture low. Across one 32-cycle scan:
  - en_out low-bit walks FE, FD, FB, F7, EF, DF, BF, 7F, each low for 3 cycles after 1 cycle of FF
  - out7 during the enabled cycles = digits 4, 3, 2, 1, 8, 0, 0, 0 (i.e. 1001100, 0000110, 0010010, 1001111, 0000000, 0000001, 0000001, 0000001)
- Hold behaviour: after the capture above, drive NumberA=32'hFFFF_FFFF with Capture=0 -> displayed digits unchanged. Pulse Capture -> digits 0-3 show F (0111000) from the next output cycle.
- Full decode sweep: capture NumberA=32'h0000_3210, 32'h0000_7654, 32'h0000_BA98, 32'h0000_FEDC in turn -> each nibble matches the decode table.
- Wrap and blanking: run 3 full scans -> dig wraps 7 -> 0 with en_out = FF for exactly BLANK_CYCLES cycles at every boundary, including the 7 -> 0 boundary. Repeat with BLANK_CYCLES=0 -> no FF cycles.
- Reset mid-scan: assert Rst during dig=5, cnt=2 -> same-cycle en_out = FF, out7 = 7F. After release, the first enabled digit is en_out = FE, and holdA = 0 so out7 = 0000001.
